// File: rtl/redirect_arbiter.sv
// redirect_arbiter
//   Picks the oldest redirect among CH execution-side channels, registers it
//   for one cycle, and drives it to the frontend/ROB. A commit-stage CSR or
//   exception redirect overrides everything combinationally and also discards
//   the channel requests of that cycle. An age filter (hold_v/hold_idx) rejects
//   requests that are not strictly older than the last accepted redirect until
//   the backend walk completes (hold_clr) or a CSR redirect occurs.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   req_en      per-channel redirect request
//   req_idx     per-channel ROB index {dir, pos}
//   req_target  per-channel redirect PC
//   req_br      per-channel "carries predictor update" flag
//   req_binfo   per-channel {taken, br_type[1:0], ras_type[1:0]}
//   csr_en      commit-stage CSR/exception redirect valid
//   csr_idx     its ROB index
//   csr_target  its redirect PC
//   hold_clr    backend walk complete, releases the age filter
//   out_en      redirect valid to frontend/ROB
//   out_idx     redirect ROB index
//   out_target  redirect PC
//   bru_en      predictor update valid
//   bru_info    predictor update payload
//   out_csr     current out_* comes from the CSR path
module redirect_arbiter #(
  parameter int CH    = 4,
  parameter int ROB_W = 6,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH-1:0]              req_en,
  input  logic [CH-1:0][ROB_W:0]     req_idx,
  input  logic [CH-1:0][PC_W-1:0]    req_target,
  input  logic [CH-1:0]              req_br,
  input  logic [CH-1:0][4:0]         req_binfo,
  input  logic                       csr_en,
  input  logic [ROB_W:0]             csr_idx,
  input  logic [PC_W-1:0]            csr_target,
  input  logic                       hold_clr,
  output logic                       out_en,
  output logic [ROB_W:0]             out_idx,
  output logic [PC_W-1:0]            out_target,
  output logic                       bru_en,
  output logic [4:0]                 bru_info,
  output logic                       out_csr
);

  localparam int IW = ROB_W + 1;
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  // Stage register and age-filter state
  logic            p_v;
  logic [IW-1:0]   p_idx;
  logic [PC_W-1:0] p_target;
  logic            p_br;
  logic [4:0]      p_binfo;
  logic            hold_v;
  logic [IW-1:0]   hold_idx;

  // Selection results
  logic [CH-1:0]   elig;
  logic            win_v;
  logic [SW-1:0]   win_sel;
  logic [IW-1:0]   win_idx;
  logic            accept;

  // The dir bit flips on every ROB wrap, so a differing dir reverses the
  // meaning of the position comparison. Equal indices are never older.
  function automatic logic is_older(input logic [IW-1:0] a, input logic [IW-1:0] b);
    if (a[IW-1] == b[IW-1]) return a[IW-2:0] < b[IW-2:0];
    else                    return a[IW-2:0] > b[IW-2:0];
  endfunction

  // Linear scan; a later channel only replaces the current winner when it is
  // strictly older, so ties keep the lowest channel number.
  always_comb begin
    elig    = '0;
    win_v   = 1'b0;
    win_sel = '0;
    win_idx = '0;
    for (int i = 0; i < CH; i++) begin
      elig[i] = req_en[i] && (!hold_v || is_older(req_idx[i], hold_idx));
      if (elig[i] && (!win_v || is_older(req_idx[i], win_idx))) begin
        win_v   = 1'b1;
        win_sel = SW'(i);
        win_idx = req_idx[i];
      end
    end
  end

  // A CSR redirect discards every channel request of its cycle.
  assign accept = win_v && !csr_en;

  // Stage register plus age filter. An accepted win beats a same-cycle
  // hold_clr so the filter stays armed on the new winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_v      <= 1'b0;
      p_idx    <= '0;
      p_target <= '0;
      p_br     <= 1'b0;
      p_binfo  <= '0;
      hold_v   <= 1'b0;
      hold_idx <= '0;
    end else begin
      p_v <= accept;
      if (accept) begin
        p_idx    <= win_idx;
        p_target <= req_target[win_sel];
        p_br     <= req_br[win_sel];
        p_binfo  <= req_binfo[win_sel];
        hold_v   <= 1'b1;
        hold_idx <= win_idx;
      end else if (hold_clr || csr_en) begin
        hold_v <= 1'b0;
      end
    end
  end

  // Output mux: the CSR path bypasses the stage register in the same cycle.
  always_comb begin
    out_en     = p_v;
    out_idx    = p_idx;
    out_target = p_target;
    out_csr    = 1'b0;
    bru_en     = p_v & p_br;
    bru_info   = p_binfo;
    if (csr_en) begin
      out_en     = 1'b1;
      out_idx    = csr_idx;
      out_target = csr_target;
      out_csr    = 1'b1;
      bru_en     = 1'b0;
    end
  end

endmodule
